// File: rtl/tug_round_controller.sv
// Round sequencer for the tug-of-war playfield: detects round wins, keeps score,
// and freezes / re-centres the light chain between rounds until a player wins the game.
module tug_round_controller #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic [NUM_LIGHTS-1:0] leds,
  output logic                  freeze,
  output logic                  field_reset,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic [1:0]            round_winner,
  output logic                  game_over
);

  localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    HOLD  = 2'b01,
    CLEAR = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
  logic [1:0]         winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               left_win, right_win;
  logic [SCORE_W-1:0] left_inc, right_inc;

  // A simultaneous L and R press can never satisfy either term.
  assign left_win  = leds[NUM_LIGHTS-1] & L & ~R;
  assign right_win = leds[0] & R & ~L;
  assign left_inc  = left_q + SCORE_W'(1);
  assign right_inc = right_q + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      left_q   <= '0;
      right_q  <= '0;
      winner_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    freeze      = 1'b0;
    field_reset = 1'b0;
    game_over   = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (left_win && !right_win) begin
          left_d   = left_inc;
          winner_d = 2'b10;
          cnt_d    = '0;
          state_d  = (left_inc == SCORE_W'(WIN_SCORE)) ? OVER : HOLD;
        end else if (right_win && !left_win) begin
          right_d  = right_inc;
          winner_d = 2'b01;
          cnt_d    = '0;
          state_d  = (right_inc == SCORE_W'(WIN_SCORE)) ? OVER : HOLD;
        end
      end
      HOLD: begin
        freeze = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // Cell reset outranks lose inside the cells, so freeze may stay high here.
        freeze      = 1'b1;
        field_reset = 1'b1;
        winner_d    = 2'b00;
        state_d     = PLAY;
      end
      OVER: begin
        freeze    = 1'b1;
        game_over = 1'b1;
      end
      default: state_d = PLAY;
    endcase
  end

  assign left_score   = left_q;
  assign right_score  = right_q;
  assign round_winner = winner_q;

endmodule
